// File: rtl/branch_pkg.sv
// Shared types and constants for the branch prediction controller.
//   Branch funct3 encodings, BHT counter states, BTB entry layout and the
//   saturating counter step function.
package branch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BTB_TAG_W = 30;   // wide enough for any BTB depth >= 1

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        STK = 2'b11
    } bht_state_t;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      target;
    } btb_entry_t;

    // Two-bit saturating step toward the observed direction.
    function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
        bht_state_t nxt;
        nxt = cur;
        if (taken && cur != STK) begin
            nxt = bht_state_t'(2'(cur) + 2'd1);
        end else if (!taken && cur != SNT) begin
            nxt = bht_state_t'(2'(cur) - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/Branch_Comparision.sv
// Shared branch comparator: evaluates the branch condition selected by B_type.
//   A, B    : operands (rs1, rs2)
//   B_type  : funct3 of the branch; undefined encodings resolve not-taken
//   Branch  : 1 when the branch condition holds
module Branch_Comparision
    import branch_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  B_type,
    output logic        Branch
);

    always_comb begin
        Branch = 1'b0;
        case (B_type)
            BEQ:     Branch = (A == B);
            BNE:     Branch = (A != B);
            BLT:     Branch = ($signed(A) <  $signed(B));
            BGE:     Branch = ($signed(A) >= $signed(B));
            BLTU:    Branch = (A <  B);
            BGEU:    Branch = (A >= B);
            default: Branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters.
//   rd_idx/rd_taken : combinational lookup, returns counter MSB (pre-update value)
//   upd_en/upd_idx/upd_taken : saturating train on the clock edge
module branch_bht
    import branch_pkg::*;
#(
    parameter  int unsigned ENTRIES = 64,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_state_t cnt [ENTRIES];

    // Counters start weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt[i] <= WNT;
            end
        end else if (upd_en) begin
            cnt[upd_idx] <= bht_next(cnt[upd_idx], upd_taken);
        end
    end

    assign rd_taken = (cnt[rd_idx] == WT) || (cnt[rd_idx] == STK);

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and resolution controller.
//   IF : if_valid/if_pc -> if_pred_taken/if_pred_target (combinational BHT+BTB lookup)
//   EX : ex_* resolves the branch via the shared comparator and trains BHT/BTB
//   Out: redirect_valid/redirect_pc (registered flush pulse), saturating
//        branch_cnt and mispredict_cnt
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic [31:0]      if_pred_target,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);

    // Tag is the pc above the index bits; zero-extended to the common field width.
    function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
        return BTB_TAG_W'(pc >> (BTB_IDX_W + 2));
    endfunction

    btb_entry_t btb [BTB_ENTRIES];

    logic        bht_taken_c;
    logic        taken_c;
    logic        res_c;
    logic        mis_c;
    logic        btb_hit_c;
    logic [31:0] redirect_pc_c;
    btb_entry_t  if_entry_c;

    Branch_Comparision u_cmp (
        .A      (ex_rs1),
        .B      (ex_rs2),
        .B_type (ex_funct3),
        .Branch (taken_c)
    );

    branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[BHT_IDX_W+1:2]),
        .rd_taken  (bht_taken_c),
        .upd_en    (res_c),
        .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
        .upd_taken (taken_c)
    );

    // IF lookup reads current table state, so a same-cycle update is seen next cycle.
    assign if_entry_c     = btb[if_pc[BTB_IDX_W+1:2]];
    assign btb_hit_c      = if_entry_c.valid && (if_entry_c.tag == tag_of(if_pc));
    assign if_pred_taken  = if_valid && bht_taken_c && btb_hit_c;
    assign if_pred_target = if_valid ? if_entry_c.target : 32'd0;

    // The EX instruction during a redirect cycle is wrong-path and must not resolve.
    assign res_c = ex_valid && ex_is_branch && !ex_stall && !redirect_valid;
    assign mis_c = res_c && ((taken_c != ex_pred_taken) ||
                             (taken_c && (ex_pred_target != ex_target)));

    always_comb begin
        redirect_pc_c = ex_pc + 32'd4;
        if (taken_c) begin
            redirect_pc_c = ex_target;
        end
    end

    // Redirect pulse toward fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            redirect_valid <= mis_c;
            if (mis_c) begin
                redirect_pc <= redirect_pc_c;
            end
        end
    end

    // BTB only learns taken branches; not-taken never invalidates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb[i] <= '0;
            end
        end else if (res_c && taken_c) begin
            btb[ex_pc[BTB_IDX_W+1:2]] <= '{valid: 1'b1, tag: tag_of(ex_pc), target: ex_target};
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (res_c && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mis_c && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
